// File: rtl/vec_normalize.sv
`default_nettype none
// ============================================================================
// Module      : vec_normalize
// Description : Front/back end around the inverse-norm unit. It collects N
//               signed elements, buffers them and accumulates their sum of
//               squares. It hands that sum to the inverse-norm unit and takes
//               back the Q15 1/sqrt mantissa and its leading-zero scale. It
//               then streams each buffered element scaled to unit norm as a
//               saturated Q15 value.
// Ports       : clk, nrst              - clock, async active-low reset
//               in_valid/in_ready/in_data    - element input stream
//               sq_valid/sq_data             - sum of squares to inverse-norm
//               inv_valid/inv_data/inv_scale - inverse-norm result
//               out_valid/out_ready/out_data/out_last - normalised stream
//               busy                         - vector in progress
// Revision    : 1.0 - initial release
// ============================================================================
module vec_normalize #(
    parameter int N  = 16,
    parameter int DW = 12
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 sq_valid,
    output logic        [31:0]   sq_data,
    input  logic                 inv_valid,
    input  logic signed [31:0]   inv_data,
    input  logic        [5:0]    inv_scale,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [15:0]   out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    localparam logic signed [47:0] SAT_MAX = 48'sd32767;
    localparam logic signed [47:0] SAT_MIN = -48'sd32768;
    localparam logic signed [47:0] INV_SQRT2_Q15 = 48'sd23170;

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_SEND    = 3'd1,
        S_WAIT    = 3'd2,
        S_CALC    = 3'd3,
        S_EMIT    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic        [CW-1:0] r_count;
    logic        [IW-1:0] r_idx;
    logic        [31:0]   r_acc;
    logic signed [DW-1:0] r_buf [N];
    logic signed [31:0]   r_inv_data;
    logic        [5:0]    r_inv_scale;
    logic signed [31:0]   r_f;
    logic        [3:0]    r_k;

    logic                 w_xfer;
    logic        [2*DW-1:0] w_sq;
    logic        [31:0]   w_acc_next;
    logic                 w_last_in;
    logic                 w_out_xfer;
    logic        [IW-1:0] w_sel;
    logic signed [DW-1:0] w_elem;
    logic signed [47:0]   w_prod;
    logic signed [47:0]   w_shift;
    logic signed [15:0]   w_sat;
    logic        [4:0]    w_p;
    logic signed [47:0]   w_odd_prod;
    logic                 w_unused;

    assign in_ready   = (r_state == S_COLLECT);
    assign sq_valid   = (r_state == S_SEND);
    assign busy       = !((r_state == S_COLLECT) && (r_count == '0));

    assign w_xfer     = in_valid && in_ready;
    // Square of a signed element is non-negative and fits in 2*DW bits.
    assign w_sq       = in_data * in_data;
    assign w_acc_next = r_acc + 32'(w_sq);
    assign w_last_in  = (r_count == CW'(N - 1));
    assign w_out_xfer = out_valid && out_ready;

    // On an accepted output the next element is loaded in the same cycle, so
    // the product is taken from idx+1; otherwise from the element at idx.
    assign w_sel   = w_out_xfer ? (r_idx + IW'(1)) : r_idx;
    assign w_elem  = r_buf[w_sel];
    assign w_prod  = $signed({{(48-DW){w_elem[DW-1]}}, w_elem}) *
                     $signed({{16{r_f[31]}}, r_f});
    assign w_shift = w_prod >>> r_k;
    assign w_sat   = (w_shift > SAT_MAX) ? 16'sh7fff :
                     (w_shift < SAT_MIN) ? 16'sh8000 : w_shift[15:0];

    // Odd exponent: fold the leftover sqrt(2) into the mantissa.
    assign w_p        = 5'd31 - r_inv_scale[4:0];
    assign w_odd_prod = $signed({{16{r_inv_data[31]}}, r_inv_data}) * INV_SQRT2_Q15;
    assign w_unused   = ^{w_odd_prod[47], w_odd_prod[14:0]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_COLLECT: begin
                if (w_xfer && w_last_in) begin
                    w_next = (w_acc_next != 32'd0) ? S_SEND : S_EMIT;
                end
            end
            S_SEND:  w_next = S_WAIT;
            S_WAIT: begin
                if (inv_valid) begin
                    w_next = S_CALC;
                end
            end
            S_CALC:  w_next = S_EMIT;
            S_EMIT: begin
                if (w_out_xfer && out_last) begin
                    w_next = S_COLLECT;
                end
            end
            default: w_next = S_COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Element buffer (no reset needed: always written before being read)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_buf[r_count[IW-1:0]] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count     <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            sq_data     <= '0;
            r_inv_data  <= '0;
            r_inv_scale <= '0;
            r_f         <= '0;
            r_k         <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_xfer) begin
                        r_acc   <= w_acc_next;
                        r_count <= r_count + CW'(1);
                        if (w_last_in) begin
                            if (w_acc_next != 32'd0) begin
                                sq_data <= w_acc_next;
                            end else begin
                                // All-zero vector: every output is zero.
                                r_f <= '0;
                                r_k <= '0;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (inv_valid) begin
                        r_inv_data  <= inv_data;
                        r_inv_scale <= inv_scale;
                    end
                end
                S_CALC: begin
                    if (r_inv_scale > 6'd31) begin
                        r_f <= '0;
                        r_k <= '0;
                    end else begin
                        r_k <= w_p[4:1];
                        r_f <= w_p[0] ? w_odd_prod[46:15] : r_inv_data;
                    end
                end
                S_EMIT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= w_sat;
                        out_last  <= (r_idx == IW'(N - 1));
                    end else if (w_out_xfer) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            r_idx     <= '0;
                            r_count   <= '0;
                            r_acc     <= '0;
                        end else begin
                            r_idx    <= r_idx + IW'(1);
                            out_data <= w_sat;
                            out_last <= (r_idx == IW'(N - 2));
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/vec_normalize.md
Name: vec_normalize

Overview:
- Vector normalisation front/back end around the inverse-norm unit.
- Accepts a stream of N signed elements, buffers them and accumulates the sum of squares.
- Sends that sum to the inverse-norm unit, then receives the 1/sqrt mantissa and leading-zero scale back.
- Emits each buffered element scaled to unit norm as a Q15 stream with valid/ready handshake.

Parameters:
- N, 16: elements per vector, 2..64.
- DW, 12: signed input element width. N*2^(2*DW-2) must fit in 32 bits.

Ports:
- clk  in  1  clock
- nrst  in  1  reset: nrst, asynchronous, active-low; clock clk
- in_valid  in  1  input element valid
- in_ready  out  1  block accepts an element
- in_data  in  DW  signed element
- sq_valid  out  1  one-cycle pulse; sum of squares valid (to inverse-norm valid_in)
- sq_data  out  32  unsigned sum of squares (to inverse-norm d_in)
- inv_valid  in  1  inverse-norm result valid
- inv_data  in  32  signed Q15 value of 1/sqrt(m), where m = normalised mantissa in [1,2)
- inv_scale  in  6  leading-zero count lz of sq_data
- out_valid  out  1  normalised element valid
- out_ready  in  1  downstream accepts
- out_data  out  16  signed Q15 normalised element, saturated
- out_last  out  1  marks element N-1 of a vector
- busy  out  1  high in any state other than COLLECT with count 0

Behaviour:
- FSM states: COLLECT, SEND, WAIT, CALC, EMIT. Reset state is COLLECT.
- Reset values:
  - count = 0, idx = 0, acc = 0.
  - sq_valid = 0, sq_data = 0, out_valid = 0, out_last = 0, busy = 0.
  - Latched f = 0, k = 0.
  - in_ready = 1 (combinational: state == COLLECT).
- COLLECT:
  - A transfer occurs when in_valid && in_ready.
  - On each transfer: buf[count] <= in_data, acc += in_data*in_data (unsigned 32-bit), count++.
  - On the transfer with count == N-1:
    - If the final acc (including this element) != 0: go to SEND and register sq_data = final acc.
    - If the final acc == 0: skip to EMIT with f = 0 and k = 0. No sq_valid is issued.
- SEND: sq_valid = 1 for exactly one cycle, then go to WAIT. sq_data holds its value until the next SEND.
- WAIT:
  - On inv_valid: latch inv_data and inv_scale, go to CALC.
  - inv_valid in any other state is ignored.
- CALC (one cycle):
  - If inv_scale > 31: treat as a zero norm, f = 0.
  - Otherwise p = 31 - inv_scale, k = p >> 1.
    - f = inv_data when p is even.
    - f = (inv_data * 23170) >>> 15 when p is odd (1/sqrt2 correction).
  - Go to EMIT.
  - Latency: inv_valid sampled at edge T gives out_valid = 1 after edge T+2.
- EMIT:
  - out_valid = 1.
  - out_data = sat16((buf[idx] * f) >>> k), using a 48-bit signed product and an arithmetic (floor) shift.
  - Saturation range is [-32768, 32767].
  - out_last = (idx == N-1).
  - out_data and out_last are driven only from registers. They stay stable while out_ready = 0.
  - On out_valid && out_ready: idx++.
  - On the last element: idx = 0, count = 0, acc = 0, go to COLLECT.
- No overlap between vectors: in_ready = 0 outside COLLECT.
- Asynchronous reset in any state aborts the vector. The next vector starts clean.

Test Plan:
- N=4, input 3,4,0,0:
  - sq_data = 25 with one sq_valid pulse.
  - Bench returns inv_data = 26214, inv_scale = 27 (k = 2).
  - Outputs 19660, 26214, 0, 0. out_last on the 4th output.
  - First out_valid 2 cycles after inv_valid.
- Odd exponent, input 1,1,0,0:
  - sq_data = 2. Bench returns inv_data = 32768, inv_scale = 30.
  - Outputs 23170, 23170, 0, 0.
- Sign and saturation:
  - Input -3,4,0,0 with inv_data = 26214, inv_scale = 27: first output = -19661.
  - Input 2047,0,0,0 with inv_data = 65535, inv_scale = 31: first output = 32767.
- Zero vector, input 0,0,0,0:
  - sq_valid never asserted.
  - Four outputs of 0 start one cycle after the last input transfer.
- Backpressure: out_ready low for 5 cycles mid-vector.
  - out_data and out_last stay constant.
  - No element is lost or duplicated.
  - in_ready stays 0 until the last output transfer.
  - A stray inv_valid during EMIT has no effect.
- Reset mid-EMIT after 2 outputs:
  - All outputs return to reset values and in_ready = 1.
  - The next vector 3,4,0,0 produces the correct 4 outputs.
